// File: rtl/jk_seq_pkg.sv
// Shared types for the JK count sequencer: FSM states, bank actions and the
// per-bit mapping from an action plus data bit to a J/K drive pair.
package jk_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } jk_state_e;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_TOGGLE,
        ACT_LOAD,
        ACT_CLEAR
    } jk_act_e;

    typedef struct packed {
        logic j;
        logic k;
    } jk_pair_t;

    // TOGGLE: d is the toggle mask bit; LOAD: d is the value to store.
    function automatic jk_pair_t jk_drive(jk_act_e act, logic d);
        jk_pair_t p;
        p = '0;
        case (act)
            ACT_TOGGLE: begin
                p.j = d;
                p.k = d;
            end
            ACT_LOAD: begin
                p.j = d;
                p.k = ~d;
            end
            ACT_CLEAR: begin
                p.j = 1'b0;
                p.k = 1'b1;
            end
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/jk_count_sequencer_if.sv
// Request/observation bundle between control logic and jk_count_sequencer.
// master (requester): drives START, UP, LIMIT, STEP_EN, ABORT.
// slave (sequencer):  drives Q, J_DRV, K_DRV, BUSY, DONE, TC.
interface jk_count_sequencer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             START;
    logic             UP;
    logic [WIDTH-1:0] LIMIT;
    logic             STEP_EN;
    logic             ABORT;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] J_DRV;
    logic [WIDTH-1:0] K_DRV;
    logic             BUSY;
    logic             DONE;
    logic             TC;

    modport master (
        output START, UP, LIMIT, STEP_EN, ABORT,
        input  Q, J_DRV, K_DRV, BUSY, DONE, TC
    );

    modport slave (
        input  START, UP, LIMIT, STEP_EN, ABORT,
        output Q, J_DRV, K_DRV, BUSY, DONE, TC
    );
endinterface

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH positive-edge JK flip-flops with asynchronous active-high clear.
// Ports: CLK, RST; j/k per-bit drive; q bank state.
module jk_reg_bank #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Characteristic equation: Q+ = J&~Q | ~K&Q
    always_comb begin
        q_d = (j & ~q_q) | (~k & q_q);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/jk_count_sequencer.sv
// Sequences a JK flip-flop bank as a bounded up/down step counter with a
// start/busy/done handshake.
// Ports: CLK, RST (async, active high); bus (slave modport) carrying
//   START/UP/LIMIT/STEP_EN/ABORT in and Q/J_DRV/K_DRV/BUSY/DONE/TC out.
// Build option: JK_AUTORELOAD_EN keeps the run going, reloading the start
//   value at the terminal count and pulsing DONE with BUSY held high.
module jk_count_sequencer
    import jk_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    jk_count_sequencer_if.slave   bus
);
    jk_state_e        state_q, state_d;
    logic             up_q, up_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    jk_act_e          act;
    logic [WIDTH-1:0] act_data;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j_drv;
    logic [WIDTH-1:0] k_drv;
    logic [WIDTH-1:0] terminal;
    logic             tc;

    assign terminal = up_q ? limit_q : '0;
    assign tc       = (q == terminal);

    // Toggle mask: bit i flips when all lower bits are 1 (up) or 0 (down)
    always_comb begin
        logic run;
        t   = '0;
        run = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            t[i] = run;
            run  = run & (up_q ? q[i] : ~q[i]);
        end
    end

    // Next-state and action selection
    always_comb begin
        state_d  = state_q;
        up_d     = up_q;
        limit_d  = limit_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        act      = ACT_HOLD;
        act_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    up_d    = bus.UP;
                    limit_d = bus.LIMIT;
                    if (bus.LIMIT == '0) begin
                        act     = ACT_CLEAR;
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        act      = ACT_LOAD;
                        act_data = bus.UP ? '0 : bus.LIMIT;
                        state_d  = ST_RUN;
                        busy_d   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                if (bus.ABORT) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (bus.STEP_EN) begin
`ifdef JK_AUTORELOAD_EN
                    // Stepping from the terminal value restarts the count
                    if (tc) begin
                        act      = ACT_LOAD;
                        act_data = up_q ? '0 : limit_q;
                        done_d   = 1'b1;
                    end else begin
                        act      = ACT_TOGGLE;
                        act_data = t;
                    end
`else
                    act      = ACT_TOGGLE;
                    act_data = t;
                    // Finish on the edge that lands on the terminal value
                    if ((q ^ t) == terminal) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-bit J/K drive for the selected action
    always_comb begin
        jk_pair_t pair;
        j_drv = '0;
        k_drv = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pair     = jk_drive(act, act_data[i]);
            j_drv[i] = pair.j;
            k_drv[i] = pair.k;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            up_q    <= 1'b1;
            limit_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            up_q    <= up_d;
            limit_q <= limit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    jk_reg_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .CLK (CLK),
        .RST (RST),
        .j   (j_drv),
        .k   (k_drv),
        .q   (q)
    );

    assign bus.Q     = q;
    assign bus.J_DRV = j_drv;
    assign bus.K_DRV = k_drv;
    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;
    assign bus.TC    = tc;
endmodule
